// File: rtl/bus_dtack_generator.sv
// bus_dtack_generator
// Generates the 68k DTACK_L from per-region wait-state counts and forwards the
// acknowledge of handshaking slaves (DRAM, CAN). Raises BERR_L when a bus
// cycle stays unacknowledged for TIMEOUT clocks. Unmapped addresses are caught
// the same way. DTACK_L, BERR_L and ActiveRegion are driven straight from flops.
module bus_dtack_generator #(
  parameter int ROM_WAIT = 0,
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 3,
  parameter int VGA_WAIT = 2,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 200
) (
  input  logic       Clk,
  input  logic       Reset_H,
  input  logic       AS_L,
  input  logic       UDS_L,
  input  logic       LDS_L,
  input  logic       OnChipRomSelect_H,
  input  logic       OnChipRamSelect_H,
  input  logic       IOSelect_H,
  input  logic       DramSelect_H,
  input  logic       CanBusSelect_H,
  input  logic       vga_select_H,
  input  logic       DramDtack_L,
  input  logic       CanBusDtack_L,
  output logic       DTACK_L,
  output logic       BERR_L,
  output logic [2:0] ActiveRegion
);

  localparam logic [2:0] REG_NONE = 3'd0;
  localparam logic [2:0] REG_ROM  = 3'd1;
  localparam logic [2:0] REG_RAM  = 3'd2;
  localparam logic [2:0] REG_IO   = 3'd3;
  localparam logic [2:0] REG_DRAM = 3'd4;
  localparam logic [2:0] REG_CAN  = 3'd5;
  localparam logic [2:0] REG_VGA  = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_EXTWAIT = 3'd2,
    ST_ACK     = 3'd3,
    ST_BERR    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             dtack_l_q, dtack_l_d;
  logic             berr_l_q, berr_l_d;
  logic [2:0]       region_q, region_d;
  logic [2:0]       sel_region_s;
  logic [CNT_W-1:0] sel_wait_s;
  logic             sel_is_ext_s;
  logic             ext_ack_s;
  logic             strobes_unused_s;

  // Data strobes are informational only; the cycle start is keyed on AS_L.
  assign strobes_unused_s = UDS_L ^ LDS_L;

  // Fixed wait-state count for a region; handshaking and unmapped regions have none.
  function automatic logic [CNT_W-1:0] region_wait(input logic [2:0] r);
    logic [CNT_W-1:0] w;
    case (r)
      REG_ROM: w = CNT_W'(ROM_WAIT);
      REG_RAM: w = CNT_W'(RAM_WAIT);
      REG_IO:  w = CNT_W'(IO_WAIT);
      REG_VGA: w = CNT_W'(VGA_WAIT);
      default: w = CNT_ZERO;
    endcase
    return w;
  endfunction

  // Priority-encode the decoder selects into a region code and its wait count.
  always_comb begin
    sel_region_s = REG_NONE;
    if (OnChipRomSelect_H) begin
      sel_region_s = REG_ROM;
    end else if (OnChipRamSelect_H) begin
      sel_region_s = REG_RAM;
    end else if (IOSelect_H) begin
      sel_region_s = REG_IO;
    end else if (DramSelect_H) begin
      sel_region_s = REG_DRAM;
    end else if (CanBusSelect_H) begin
      sel_region_s = REG_CAN;
    end else if (vga_select_H) begin
      sel_region_s = REG_VGA;
    end else begin
      sel_region_s = REG_NONE;
    end
    sel_wait_s   = region_wait(sel_region_s);
    sel_is_ext_s = (sel_region_s == REG_DRAM) || (sel_region_s == REG_CAN) ||
                   (sel_region_s == REG_NONE);
  end

  // Pick the acknowledge source of the latched region; region 0 has none.
  always_comb begin
    case (region_q)
      REG_DRAM: ext_ack_s = ~DramDtack_L;
      REG_CAN:  ext_ack_s = ~CanBusDtack_L;
      default:  ext_ack_s = 1'b0;
    endcase
  end

  // Next-state logic for the cycle FSM, its counters and the registered strobes.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    dtack_l_d = dtack_l_q;
    berr_l_d  = berr_l_q;
    region_d  = region_q;
    case (state_q)
      ST_IDLE: begin
        if (!AS_L) begin
          region_d = sel_region_s;
          tcnt_d   = CNT_ZERO;
          wcnt_d   = sel_wait_s;
          if (sel_is_ext_s) begin
            state_d = ST_EXTWAIT;
          end else if (sel_wait_s == CNT_ZERO) begin
            state_d   = ST_ACK;
            dtack_l_d = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          dtack_l_d = 1'b1;
          berr_l_d  = 1'b1;
          region_d  = REG_NONE;
        end
      end
      ST_WAIT: begin
        if (AS_L) begin
          state_d  = ST_IDLE;
          region_d = REG_NONE;
        end else if (wcnt_q <= CNT_ONE) begin
          state_d   = ST_ACK;
          dtack_l_d = 1'b0;
        end else if (tcnt_q >= TIMEOUT_LAST) begin
          state_d  = ST_BERR;
          berr_l_d = 1'b0;
          tcnt_d   = TIMEOUT_MAX;
        end else begin
          wcnt_d = wcnt_q - CNT_ONE;
          tcnt_d = tcnt_q + CNT_ONE;
        end
      end
      ST_EXTWAIT: begin
        if (AS_L) begin
          state_d  = ST_IDLE;
          region_d = REG_NONE;
        end else if (ext_ack_s) begin
          state_d   = ST_ACK;
          dtack_l_d = 1'b0;
        end else if (tcnt_q >= TIMEOUT_LAST) begin
          state_d  = ST_BERR;
          berr_l_d = 1'b0;
          tcnt_d   = TIMEOUT_MAX;
        end else begin
          tcnt_d = tcnt_q + CNT_ONE;
        end
      end
      ST_ACK, ST_BERR: begin
        if (AS_L) begin
          state_d   = ST_IDLE;
          dtack_l_d = 1'b1;
          berr_l_d  = 1'b1;
          region_d  = REG_NONE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        wcnt_d    = CNT_ZERO;
        tcnt_d    = CNT_ZERO;
        dtack_l_d = 1'b1;
        berr_l_d  = 1'b1;
        region_d  = REG_NONE;
      end
    endcase
  end

  // State and output flops; reset overrides any cycle in progress.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= CNT_ZERO;
      tcnt_q    <= CNT_ZERO;
      dtack_l_q <= 1'b1;
      berr_l_q  <= 1'b1;
      region_q  <= REG_NONE;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      dtack_l_q <= dtack_l_d;
      berr_l_q  <= berr_l_d;
      region_q  <= region_d;
    end
  end

  assign DTACK_L      = dtack_l_q;
  assign BERR_L       = berr_l_q;
  assign ActiveRegion = region_q;

endmodule
